// File: rtl/digit_match_sched_pkg.sv
// Shared defaults, FSM encoding and packed-slice helper for the digit
// recogniser's best-template scheduler.
package digit_match_sched_pkg;

  localparam int W_DEF    = 12;
  localparam int N_DEF    = 10;
  localparam int IDXW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/digit_match_sched_max_cmp_stage.sv
// Registered (value, index) running-maximum stage. A load seeds it; an enable
// replaces the held pair only when the candidate is strictly greater.
module max_cmp_stage
  import digit_match_sched_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [W-1:0]    cand_val_i,
  input  logic [IDXW-1:0] cand_idx_i,
  output logic [W-1:0]    max_o,
  output logic [IDXW-1:0] idx_o
);

  logic [W-1:0]    max_q;
  logic [IDXW-1:0] idx_q;

  // Strict compare keeps the earliest index on ties.
  always_ff @(posedge pclk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (load_i || (en_i && (cand_val_i > max_q))) begin
      max_q <= cand_val_i;
      idx_q <= cand_idx_i;
    end
  end

  assign max_o = max_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/digit_match_sched.sv
// Serial best-template selector: latches N scores, scans them through one
// comparator and strobes max/idx/hit with a start/busy/valid handshake.
module digit_match_sched
  import digit_match_sched_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  scores,
  input  logic [W-1:0]    thresh,
  output logic            busy,
  output logic            valid,
  output logic [W-1:0]    max,
  output logic [IDXW-1:0] idx,
  output logic            hit
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e          state_q;
  logic [N*W-1:0]  scores_q;
  logic [W-1:0]    thresh_q;
  logic [IDXW-1:0] i_q;

  logic            cmp_load_d;
  logic            cmp_en_d;
  logic [W-1:0]    cand_val_d;
  logic [IDXW-1:0] cand_idx_d;
  logic [W-1:0]    run_max;
  logic [IDXW-1:0] run_idx;

  // Seeding takes score[0] straight from the input on the accepting edge.
  always_comb begin
    cmp_load_d = (state_q == IDLE) && start;
    cmp_en_d   = (state_q == SCAN);
    if (cmp_load_d) begin
      cand_val_d = scores[W-1:0];
      cand_idx_d = '0;
    end else begin
      cand_val_d = scores_q[slice_off(int'(i_q), W) +: W];
      cand_idx_d = i_q;
    end
  end

  max_cmp_stage #(.W(W), .IDXW(IDXW)) u_cmp (
    .pclk       (pclk),
    .rst        (rst),
    .load_i     (cmp_load_d),
    .en_i       (cmp_en_d),
    .cand_val_i (cand_val_d),
    .cand_idx_i (cand_idx_d),
    .max_o      (run_max),
    .idx_o      (run_idx)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= IDLE;
      scores_q <= '0;
      thresh_q <= '0;
      i_q      <= '0;
      valid    <= 1'b0;
      max      <= '0;
      idx      <= '0;
      hit      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            scores_q <= scores;
            thresh_q <= thresh;
            i_q      <= IDXW'(1);
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          // Park the counter at 0 after the last compare so it never wraps.
          if (i_q == LAST_IDX) begin
            i_q     <= '0;
            state_q <= DONE;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        DONE: begin
          max     <= run_max;
          idx     <= run_idx;
          hit     <= (run_max >= thresh_q);
          valid   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_digit_match_sched.sv
// Directed bench for digit_match_sched: reset, scans, ties, thresholds,
// ignored start, back-to-back scans and mid-scan reset.
module tb_digit_match_sched;

  localparam int W    = 12;
  localparam int N    = 10;
  localparam int IDXW = 4;

  logic            pclk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [N*W-1:0]  scores;
  logic [W-1:0]    thresh = '0;
  logic            busy;
  logic            valid;
  logic [W-1:0]    max_o;
  logic [IDXW-1:0] idx_o;
  logic            hit;

  logic [W-1:0] sc [N];
  int vec_cnt  = 0;
  int miss_cnt = 0;
  int valid_cnt;

  always #5 pclk = ~pclk;

  always_comb begin
    scores = '0;
    for (int k = 0; k < N; k++) scores[k*W +: W] = sc[k];
  end

  digit_match_sched #(.W(W), .N(N), .IDXW(IDXW)) dut (
    .pclk   (pclk),
    .rst    (rst),
    .start  (start),
    .scores (scores),
    .thresh (thresh),
    .busy   (busy),
    .valid  (valid),
    .max    (max_o),
    .idx    (idx_o),
    .hit    (hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic b, input logic v,
                          input logic [W-1:0] m, input logic [IDXW-1:0] i, input logic h);
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".max"},   32'(max_o), 32'(m));
    chk({tag, ".idx"},   32'(idx_o), 32'(i));
    chk({tag, ".hit"},   32'(hit),   32'(h));
  endtask

  // Called at the falling edge right after the accepting edge. Walks to the
  // valid cycle, checking held outputs en route. poke: scramble inputs and
  // pulse start throughout the scan.
  task automatic scan_check(input string tag,
                            input logic [W-1:0] pm, input logic [IDXW-1:0] pi, input logic ph,
                            input logic [W-1:0] em, input logic [IDXW-1:0] ei, input logic eh,
                            input bit poke);
    for (int j = 0; j < N; j++) begin
      chk_outs($sformatf("%s.j%0d", tag, j), 1'b1, 1'b0, pm, pi, ph);
      if (poke) begin
        for (int k = 0; k < N; k++) sc[k] = 12'hFFF;
        thresh = 12'hFFF;
        start  = 1'b1;
      end
      @(negedge pclk);
    end
    start = 1'b0;
    chk_outs({tag, ".result"}, 1'b0, 1'b1, em, ei, eh);
    $display("scan %s: max=%0d idx=%0d hit=%0d", tag, max_o, idx_o, hit);
  endtask

  task automatic accept();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) sc[k] = '0;

    // Reset then idle
    @(negedge pclk);
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_outs($sformatf("idle.c%0d", c), 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge pclk);
    end
    $display("reset/idle: 20 cycles checked");

    // Single scan with a tie between index 3 and 5
    sc = '{100, 200, 50, 900, 3, 900, 7, 8, 9, 10};
    thresh = 12'd500;
    accept();
    scan_check("tie", '0, '0, 1'b0, 12'd900, 4'd3, 1'b1, 1'b0);

    // Below threshold, last index wins
    @(negedge pclk);
    chk_outs("tie.hold", 1'b0, 1'b0, 12'd900, 4'd3, 1'b1);
    for (int k = 0; k < N; k++) sc[k] = 12'd5;
    sc[9] = 12'd40;
    thresh = 12'd41;
    accept();
    scan_check("last", 12'd900, 4'd3, 1'b1, 12'd40, 4'd9, 1'b0, 1'b0);

    // All zero with zero threshold
    @(negedge pclk);
    for (int k = 0; k < N; k++) sc[k] = '0;
    thresh = '0;
    accept();
    scan_check("zero", 12'd40, 4'd9, 1'b0, '0, '0, 1'b1, 1'b0);

    // Latched inputs only, start ignored while busy; thresh equality hits
    @(negedge pclk);
    sc = '{11, 21, 31, 41, 51, 61, 700, 81, 91, 101};
    thresh = 12'd700;
    accept();
    scan_check("indep", '0, '0, 1'b1, 12'd700, 4'd6, 1'b1, 1'b1);
    valid_cnt = 1;
    for (int c = 0; c < 15; c++) begin
      @(negedge pclk);
      if (valid) valid_cnt++;
    end
    chk("indep.one_valid", 32'(valid_cnt), 32'd1);
    chk("indep.idle", 32'(busy), 32'd0);

    // Back-to-back: new start in the valid cycle
    sc = '{100, 200, 50, 900, 3, 900, 7, 8, 9, 10};
    thresh = 12'd500;
    accept();
    scan_check("b2b1", 12'd700, 4'd6, 1'b1, 12'd900, 4'd3, 1'b1, 1'b0);
    sc[0] = 12'hFFF;
    accept();
    scan_check("b2b2", 12'd900, 4'd3, 1'b1, 12'hFFF, '0, 1'b1, 1'b0);

    // Reset mid-scan
    @(negedge pclk);
    for (int k = 0; k < N; k++) sc[k] = 12'd77;
    thresh = 12'd1;
    accept();
    repeat (5) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk_outs("abort", 1'b0, 1'b0, '0, '0, 1'b0);
    valid_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge pclk);
      if (valid) valid_cnt++;
    end
    chk("abort.no_valid", 32'(valid_cnt), 32'd0);
    $display("abort: scan cancelled, no valid");

    // Fresh scan after abort
    for (int k = 0; k < N; k++) sc[k] = 12'd5;
    sc[9] = 12'd40;
    thresh = 12'd41;
    accept();
    scan_check("fresh", '0, '0, 1'b0, 12'd40, 4'd9, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
